// File: rtl/wm_key_pkg.sv
// ---------------------------------------------------------------------------
// wm_key_pkg : shared key indices and 24 MHz timing defaults for the panel
//              key conditioner. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wm_key_pkg;

  typedef enum int unsigned {
    KEY_START     = 0,
    KEY_WATERFULL = 1,
    KEY_STOP      = 2,
    KEY_RESET     = 3
  } wm_key_e;

  localparam int unsigned DEF_N_KEYS          = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;    // 10 ms at 24 MHz
  localparam int unsigned DEF_LONG_CYCLES     = 48000000;  // 2 s at 24 MHz
  localparam bit          DEF_ACTIVE_LOW      = 1'b1;

  // Raw pin level of an unpressed key.
  function automatic logic released_level(input bit active_low);
    return active_low;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ---------------------------------------------------------------------------
// key_debounce_ch : one key channel - 2-FF sync, polarity normalize, strict
//                   consecutive-cycle debounce, press/release strobes and,
//                   with KEY_DEBOUNCE_LONGPRESS_EN, a long-hold strobe. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce_ch
  import wm_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned     CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   ACCEPT_CNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          norm;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= released_level(ACTIVE_LOW);
      sync2_q   <= released_level(ACTIVE_LOW);
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any sample matching the accepted level restarts the count.
  always_comb begin
    norm      = sync2_q ^ ACTIVE_LOW;
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (norm != stable_q) begin
      if (cnt_q == ACCEPT_CNT) begin
        stable_d  = ~stable_q;
        press_d   = ~stable_q;
        release_d = stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int unsigned   HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 2);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Saturating at HOLD_MAX is what limits the strobe to once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!stable_q || press_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_FIRE);
    end
  end

  assign long_o = long_q;
`else
  // Hold length is irrelevant when the long-press logic is not built.
  assign long_o = 1'b0 && (LONG_CYCLES != 0);
`endif

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce : washer panel key conditioner, one independent debounce
//                channel per key. Optional long-press strobe is built when
//                KEY_DEBOUNCE_LONGPRESS_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_debounce
  import wm_key_pkg::*;
#(
  parameter int unsigned N_KEYS          = DEF_N_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (key_raw[i]),
      .level_o   (key_level[i]),
      .press_o   (press_pulse[i]),
      .release_o (release_pulse[i]),
      .long_o    (long_pulse[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce : directed key scenarios plus randomized key/reset traffic
//                   against a sample-window reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_key_debounce;

  localparam int D    = 8;
  localparam int L    = 32;
  localparam int MAXE = 16384;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key_level, press_pulse, release_pulse, long_pulse;

  int n_checks = 0;
  int n_errors = 0;

  key_debounce #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1'b1),
    .LONG_CYCLES     (L)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_raw       (key_raw),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: level flips once the last D pipeline-delayed samples
  // all disagree with it and none predate the last reset or flip.
  bit [3:0] hist [MAXE];
  bit [3:0] inp  [MAXE];
  bit       rst_at [MAXE];
  int       last_evt [4];
  int       press_edge [4];
  bit [3:0] mlev;

  initial begin
    int n;
    bit [3:0] ep, er, el;
    bit all;
    n = 0;
    mlev = '0;
    forever begin
      @(posedge clk);
      if (n < MAXE) begin
        rst_at[n] = reset;
        hist[n]   = reset ? 4'h0 : ~key_raw;
        if (n < 2)               inp[n] = 4'h0;
        else if (rst_at[n-1])    inp[n] = 4'h0;
        else                     inp[n] = hist[n-2];
        ep = '0; er = '0; el = '0;
        if (reset) begin
          mlev = '0;
          for (int c = 0; c < 4; c++) begin
            last_evt[c]   = n;
            press_edge[c] = -1000;
          end
        end else begin
          for (int c = 0; c < 4; c++) begin
            el[c] = mlev[c] && (n - press_edge[c] == L);
            all = (n - last_evt[c] >= D);
            if (all)
              for (int k = 0; k < D; k++)
                if (inp[n-k][c] == mlev[c]) all = 1'b0;
            if (all) begin
              mlev[c]     = ~mlev[c];
              last_evt[c] = n;
              if (mlev[c]) begin
                ep[c]         = 1'b1;
                press_edge[c] = n;
              end else begin
                er[c] = 1'b1;
              end
            end
          end
        end
`ifndef KEY_DEBOUNCE_LONGPRESS_EN
        el = '0;
`endif
        #1;
        chk("level",   key_level,     mlev);
        chk("press",   press_pulse,   ep);
        chk("release", release_pulse, er);
        chk("long",    long_pulse,    el);
        n++;
      end
    end
  end

  // kind: 0 press, 1 release, 2 long. Returns edges counted, or -1 on timeout.
  task automatic wait_pulse(input int ch, input int kind, output int edges);
    bit hit;
    edges = -1;
    hit = 1'b0;
    for (int i = 1; i <= 60 && !hit; i++) begin
      @(posedge clk);
      #1;
      case (kind)
        0:       hit = press_pulse[ch];
        1:       hit = release_pulse[ch];
        default: hit = long_pulse[ch];
      endcase
      if (hit) edges = i;
    end
  endtask

  initial begin
    int e;
    int rem [4];

    // 1: reset with keys released, then idle
    reset   = 1'b1;
    key_raw = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("t1_idle", {key_level, press_pulse, release_pulse, long_pulse}, 16'h0);

    // 2: clean press and release on key 0
    key_raw[0] = 1'b0;
    wait_pulse(0, 0, e);
    chk("t2_press_lat", e, 10);
    chk("t2_level", key_level[0], 1'b1);
    @(posedge clk); #1;
    chk("t2_width", press_pulse[0], 1'b0);
    @(negedge clk);
    key_raw[0] = 1'b1;
    wait_pulse(0, 1, e);
    chk("t2_release_lat", e, 10);
    @(negedge clk);

    // 3: bouncing key 1 never accepted
    for (int i = 0; i < 40; i++) begin
      key_raw[1] = ((i / 3) % 2) != 0;
      @(negedge clk);
    end
    key_raw[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_level", key_level[1], 1'b0);

    // 4: one-cycle glitch restarts the count
    key_raw[2] = 1'b0;
    repeat (7) @(negedge clk);
    key_raw[2] = 1'b1;
    @(negedge clk);
    key_raw[2] = 1'b0;
    wait_pulse(2, 0, e);
    chk("t4_press_lat", e, 10);
    @(negedge clk);
    key_raw[2] = 1'b1;
    repeat (15) @(negedge clk);

    // 5: key 3 held through reset
    key_raw[3] = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_pulse(3, 0, e);
    chk("t5_press_lat", e, 10);
    repeat (20) @(negedge clk);
    key_raw[3] = 1'b1;
    wait_pulse(3, 1, e);
    chk("t5_release_lat", e, 10);
    @(negedge clk);

    // 6: long hold on key 0
    key_raw[0] = 1'b0;
    wait_pulse(0, 0, e);
    chk("t6_press_lat", e, 10);
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
    wait_pulse(0, 2, e);
    chk("t6_long_lat", e, 32);
    repeat (60) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    chk("t6_no_long", long_pulse, 4'h0);
`endif
    key_raw[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Randomized traffic: bursts of bounce mixed with long holds, rare resets
    for (int c = 0; c < 4; c++) rem[c] = $urandom_range(1, 40);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          key_raw[c] = ~key_raw[c];
          rem[c] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5))
                                                 : int'($urandom_range(6, 60));
        end else begin
          rem[c]--;
        end
      end
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
